my_uart_tx: RTL

//  Serial UART transmitter, 8 data bits, LSB first, 1 stop bit. Feeds rs232_tx of my_uart_top.

---
 rtl/my_uart_tx.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/my_uart_tx.sv
`timescale 1ns/1ps
// UART transmitter: 8 data bits LSB first, 1 stop bit, one byte per valid/ready handshake.
// Define UART_TX_PARITY_EN to insert a parity bit (sense set by PARITY_ODD) before the stop bit.
module my_uart_tx #(
    parameter int CLK_DIV    = 5208,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       rs232_tx,
    output logic       tx_busy,
    output logic       tx_done
);
    localparam int BW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
`ifdef UART_TX_PARITY_EN
        S_PAR   = 3'd3,
`endif
        S_STOP  = 3'd4
    } state_t;

    state_t          state_q;
    logic [BW-1:0]   baud_q;
    logic [BW-1:0]   baud_d;
    logic [2:0]      bit_idx_q;
    logic [7:0]      shift_q;
    logic            tx_q;
    logic            ready_q;
    logic            busy_q;
    logic            done_q;
    logic            bit_end;
`ifdef UART_TX_PARITY_EN
    logic            parity_q;
`endif

    assign baud_d  = baud_q + 1'b1;
    assign bit_end = (baud_q == BAUD_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (tx_valid && ready_q) begin
                        shift_q   <= tx_data;
                        tx_q      <= 1'b0;
                        ready_q   <= 1'b0;
                        busy_q    <= 1'b1;
                        baud_q    <= '0;
                        bit_idx_q <= '0;
                        state_q   <= S_START;
`ifdef UART_TX_PARITY_EN
                        parity_q  <= (^tx_data) ^ PARITY_ODD;
`endif
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        baud_q  <= '0;
                        tx_q    <= shift_q[0];
                        shift_q <= {1'b0, shift_q[7:1]};
                        state_q <= S_DATA;
                    end else begin
                        baud_q <= baud_d;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        baud_q    <= '0;
                        // 3-bit index wraps 7->0 as the last data bit finishes
                        bit_idx_q <= bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            tx_q    <= parity_q;
                            state_q <= S_PAR;
`else
                            tx_q    <= 1'b1;
                            state_q <= S_STOP;
`endif
                        end else begin
                            tx_q    <= shift_q[0];
                            shift_q <= {1'b0, shift_q[7:1]};
                        end
                    end else begin
                        baud_q <= baud_d;
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PAR: begin
                    if (bit_end) begin
                        baud_q  <= '0;
                        tx_q    <= 1'b1;
                        state_q <= S_STOP;
                    end else begin
                        baud_q <= baud_d;
                    end
                end
`endif
                S_STOP: begin
                    // Line stays high in IDLE, so a back-to-back stop bit stretches by one clock
                    if (bit_end) begin
                        baud_q  <= '0;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        baud_q <= baud_d;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    tx_q    <= 1'b1;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    baud_q  <= '0;
                end
            endcase
        end
    end

    assign rs232_tx = tx_q;
    assign tx_ready = ready_q;
    assign tx_busy  = busy_q;
    assign tx_done  = done_q;

endmodule
